// File: rtl/alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_stage
//  Purpose  : Single-issue RV32I integer execute stage. The stage captures
//             one issued operation per enabled cycle and drives a registered
//             ALU common data bus one cycle later. The bus carries a register
//             result, a link value or a load/store effective address, plus
//             the branch/jump outcome and redirect target.
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec_stage #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4,
  parameter int OP_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             in_rollback,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_Vj,
  input  logic [XLEN-1:0]  in_Vk,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [ROB_W-1:0] in_rob_tag,
  output logic [ROB_W-1:0] out_cdb_rob_tag,
  output logic [XLEN-1:0]  out_cdb_data,
  output logic             out_cdb_isload,
  output logic             out_cdb_jump,
  output logic [XLEN-1:0]  out_cdb_target
);

  // --------------------------------------------------------------------------
  // Operation encodings shared with the reservation station. Anything not
  // listed here is treated as an idle slot.
  // --------------------------------------------------------------------------
  localparam logic [OP_W-1:0] c_OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] c_OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] c_OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] c_OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] c_OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] c_OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] c_OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] c_OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] c_OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] c_OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] c_OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] c_OP_LB    = 6'd11;
  localparam logic [OP_W-1:0] c_OP_LH    = 6'd12;
  localparam logic [OP_W-1:0] c_OP_LW    = 6'd13;
  localparam logic [OP_W-1:0] c_OP_LBU   = 6'd14;
  localparam logic [OP_W-1:0] c_OP_LHU   = 6'd15;
  localparam logic [OP_W-1:0] c_OP_SB    = 6'd16;
  localparam logic [OP_W-1:0] c_OP_SH    = 6'd17;
  localparam logic [OP_W-1:0] c_OP_SW    = 6'd18;
  localparam logic [OP_W-1:0] c_OP_ADDI  = 6'd19;
  localparam logic [OP_W-1:0] c_OP_SLTI  = 6'd20;
  localparam logic [OP_W-1:0] c_OP_SLTIU = 6'd21;
  localparam logic [OP_W-1:0] c_OP_XORI  = 6'd22;
  localparam logic [OP_W-1:0] c_OP_ORI   = 6'd23;
  localparam logic [OP_W-1:0] c_OP_ANDI  = 6'd24;
  localparam logic [OP_W-1:0] c_OP_SLLI  = 6'd25;
  localparam logic [OP_W-1:0] c_OP_SRLI  = 6'd26;
  localparam logic [OP_W-1:0] c_OP_SRAI  = 6'd27;
  localparam logic [OP_W-1:0] c_OP_ADD   = 6'd28;
  localparam logic [OP_W-1:0] c_OP_SUB   = 6'd29;
  localparam logic [OP_W-1:0] c_OP_SLL   = 6'd30;
  localparam logic [OP_W-1:0] c_OP_SLT   = 6'd31;
  localparam logic [OP_W-1:0] c_OP_SLTU  = 6'd32;
  localparam logic [OP_W-1:0] c_OP_XOR   = 6'd33;
  localparam logic [OP_W-1:0] c_OP_SRL   = 6'd34;
  localparam logic [OP_W-1:0] c_OP_SRA   = 6'd35;
  localparam logic [OP_W-1:0] c_OP_OR    = 6'd36;
  localparam logic [OP_W-1:0] c_OP_AND   = 6'd37;

  // Result class: selects which datapath feeds the bus.
  localparam logic [2:0] c_CLS_IDLE   = 3'd0;
  localparam logic [2:0] c_CLS_ALU    = 3'd1;
  localparam logic [2:0] c_CLS_LUI    = 3'd2;
  localparam logic [2:0] c_CLS_AUIPC  = 3'd3;
  localparam logic [2:0] c_CLS_JAL    = 3'd4;
  localparam logic [2:0] c_CLS_JALR   = 3'd5;
  localparam logic [2:0] c_CLS_BRANCH = 3'd6;
  localparam logic [2:0] c_CLS_MEM    = 3'd7;

  // ALU function, shared by register and immediate forms.
  localparam logic [3:0] c_FN_ADD  = 4'd0;
  localparam logic [3:0] c_FN_SUB  = 4'd1;
  localparam logic [3:0] c_FN_SLL  = 4'd2;
  localparam logic [3:0] c_FN_SLT  = 4'd3;
  localparam logic [3:0] c_FN_SLTU = 4'd4;
  localparam logic [3:0] c_FN_XOR  = 4'd5;
  localparam logic [3:0] c_FN_SRL  = 4'd6;
  localparam logic [3:0] c_FN_SRA  = 4'd7;
  localparam logic [3:0] c_FN_OR   = 4'd8;
  localparam logic [3:0] c_FN_AND  = 4'd9;

  // Branch condition.
  localparam logic [2:0] c_BR_EQ  = 3'd0;
  localparam logic [2:0] c_BR_NE  = 3'd1;
  localparam logic [2:0] c_BR_LT  = 3'd2;
  localparam logic [2:0] c_BR_GE  = 3'd3;
  localparam logic [2:0] c_BR_LTU = 3'd4;
  localparam logic [2:0] c_BR_GEU = 3'd5;

  localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

  logic [2:0]      op_cls;
  logic [3:0]      alu_fn;
  logic            use_imm;
  logic [2:0]      br_fn;
  logic [XLEN-1:0] opnd_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;
  logic            br_taken;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] pc_plus_4;
  logic [XLEN-1:0] vj_plus_imm;

  logic [ROB_W-1:0] tag_d,    tag_q;
  logic [XLEN-1:0]  data_d,   data_q;
  logic             isload_d, isload_q;
  logic             jump_d,   jump_q;
  logic [XLEN-1:0]  target_d, target_q;

  // Decode the issued operation into result class, ALU function and branch condition.
  always_comb begin
    op_cls  = c_CLS_IDLE;
    alu_fn  = c_FN_ADD;
    use_imm = 1'b0;
    br_fn   = c_BR_EQ;
    case (in_op)
      c_OP_LUI:   op_cls = c_CLS_LUI;
      c_OP_AUIPC: op_cls = c_CLS_AUIPC;
      c_OP_JAL:   op_cls = c_CLS_JAL;
      c_OP_JALR:  op_cls = c_CLS_JALR;
      c_OP_BEQ:   begin op_cls = c_CLS_BRANCH; br_fn = c_BR_EQ;  end
      c_OP_BNE:   begin op_cls = c_CLS_BRANCH; br_fn = c_BR_NE;  end
      c_OP_BLT:   begin op_cls = c_CLS_BRANCH; br_fn = c_BR_LT;  end
      c_OP_BGE:   begin op_cls = c_CLS_BRANCH; br_fn = c_BR_GE;  end
      c_OP_BLTU:  begin op_cls = c_CLS_BRANCH; br_fn = c_BR_LTU; end
      c_OP_BGEU:  begin op_cls = c_CLS_BRANCH; br_fn = c_BR_GEU; end
      c_OP_LB, c_OP_LH, c_OP_LW, c_OP_LBU, c_OP_LHU,
      c_OP_SB, c_OP_SH, c_OP_SW:
                  op_cls = c_CLS_MEM;
      c_OP_ADDI:  begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_ADD;  end
      c_OP_SLTI:  begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_SLT;  end
      c_OP_SLTIU: begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_SLTU; end
      c_OP_XORI:  begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_XOR;  end
      c_OP_ORI:   begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_OR;   end
      c_OP_ANDI:  begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_AND;  end
      c_OP_SLLI:  begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_SLL;  end
      c_OP_SRLI:  begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_SRL;  end
      c_OP_SRAI:  begin op_cls = c_CLS_ALU; use_imm = 1'b1; alu_fn = c_FN_SRA;  end
      c_OP_ADD:   begin op_cls = c_CLS_ALU; alu_fn = c_FN_ADD;  end
      c_OP_SUB:   begin op_cls = c_CLS_ALU; alu_fn = c_FN_SUB;  end
      c_OP_SLL:   begin op_cls = c_CLS_ALU; alu_fn = c_FN_SLL;  end
      c_OP_SLT:   begin op_cls = c_CLS_ALU; alu_fn = c_FN_SLT;  end
      c_OP_SLTU:  begin op_cls = c_CLS_ALU; alu_fn = c_FN_SLTU; end
      c_OP_XOR:   begin op_cls = c_CLS_ALU; alu_fn = c_FN_XOR;  end
      c_OP_SRL:   begin op_cls = c_CLS_ALU; alu_fn = c_FN_SRL;  end
      c_OP_SRA:   begin op_cls = c_CLS_ALU; alu_fn = c_FN_SRA;  end
      c_OP_OR:    begin op_cls = c_CLS_ALU; alu_fn = c_FN_OR;   end
      c_OP_AND:   begin op_cls = c_CLS_ALU; alu_fn = c_FN_AND;  end
      default:    op_cls = c_CLS_IDLE;
    endcase
  end

  // Second ALU operand and the shared address/link adders.
  always_comb begin
    opnd_b      = use_imm ? in_imm : in_Vk;
    shamt       = opnd_b[4:0];
    pc_plus_imm = in_pc + in_imm;
    pc_plus_4   = in_pc + c_FOUR;
    vj_plus_imm = in_Vj + in_imm;
  end

  // Integer ALU; all arithmetic wraps modulo 2^XLEN.
  always_comb begin
    alu_res = '0;
    case (alu_fn)
      c_FN_ADD:  alu_res = in_Vj + opnd_b;
      c_FN_SUB:  alu_res = in_Vj - opnd_b;
      c_FN_SLL:  alu_res = in_Vj << shamt;
      c_FN_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in_Vj) < $signed(opnd_b))};
      c_FN_SLTU: alu_res = {{(XLEN-1){1'b0}}, (in_Vj < opnd_b)};
      c_FN_XOR:  alu_res = in_Vj ^ opnd_b;
      c_FN_SRL:  alu_res = in_Vj >> shamt;
      c_FN_SRA:  alu_res = $unsigned($signed(in_Vj) >>> shamt);
      c_FN_OR:   alu_res = in_Vj | opnd_b;
      c_FN_AND:  alu_res = in_Vj & opnd_b;
      default:   alu_res = '0;
    endcase
  end

  // Branch condition evaluation on Vj versus Vk.
  always_comb begin
    br_taken = 1'b0;
    case (br_fn)
      c_BR_EQ:  br_taken = (in_Vj == in_Vk);
      c_BR_NE:  br_taken = (in_Vj != in_Vk);
      c_BR_LT:  br_taken = ($signed(in_Vj) <  $signed(in_Vk));
      c_BR_GE:  br_taken = ($signed(in_Vj) >= $signed(in_Vk));
      c_BR_LTU: br_taken = (in_Vj <  in_Vk);
      c_BR_GEU: br_taken = (in_Vj >= in_Vk);
      default:  br_taken = 1'b0;
    endcase
  end

  // Next bus contents; idle slots, tag 0 and a flush all broadcast nothing.
  always_comb begin
    tag_d    = '0;
    data_d   = '0;
    isload_d = 1'b0;
    jump_d   = 1'b0;
    target_d = '0;
    if (!in_rollback && (in_rob_tag != '0) && (op_cls != c_CLS_IDLE)) begin
      tag_d = in_rob_tag;
      case (op_cls)
        c_CLS_ALU:   data_d = alu_res;
        c_CLS_LUI:   data_d = in_imm;
        c_CLS_AUIPC: data_d = pc_plus_imm;
        c_CLS_JAL: begin
          data_d   = pc_plus_4;
          target_d = pc_plus_imm;
          jump_d   = 1'b1;
        end
        c_CLS_JALR: begin
          data_d   = pc_plus_4;
          target_d = {vj_plus_imm[XLEN-1:1], 1'b0};
          jump_d   = 1'b1;
        end
        c_CLS_BRANCH: begin
          jump_d   = br_taken;
          target_d = br_taken ? pc_plus_imm : pc_plus_4;
        end
        c_CLS_MEM: begin
          data_d   = vj_plus_imm;
          isload_d = 1'b1;
        end
        default: tag_d = '0;
      endcase
    end
  end

  // Output register: reset clears, stall holds, otherwise capture next contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= '0;
      data_q   <= '0;
      isload_q <= 1'b0;
      jump_q   <= 1'b0;
      target_q <= '0;
    end else if (ena) begin
      tag_q    <= tag_d;
      data_q   <= data_d;
      isload_q <= isload_d;
      jump_q   <= jump_d;
      target_q <= target_d;
    end
  end

  assign out_cdb_rob_tag = tag_q;
  assign out_cdb_data    = data_q;
  assign out_cdb_isload  = isload_q;
  assign out_cdb_jump    = jump_q;
  assign out_cdb_target  = target_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_stage
//  Purpose  : Self-checking bench for alu_exec_stage: directed cases followed
//             by randomized traffic compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_stage;

  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int OP_W  = 6;

  // Operation encodings as issued by the reservation station.
  localparam int NOP=0, LUI=1, AUIPC=2, JAL=3, JALR=4, BEQ=5, BNE=6, BLT=7,
                 BGE=8, BLTU=9, BGEU=10, LB=11, LH=12, LW=13, LBU=14, LHU=15,
                 SB=16, SH=17, SW=18, ADDI=19, SLTI=20, SLTIU=21, XORI=22,
                 ORI=23, ANDI=24, SLLI=25, SRLI=26, SRAI=27, ADD=28, SUB=29,
                 SLL=30, SLT=31, SLTU=32, XOR=33, SRL=34, SRA=35, OR=36, AND=37;

  typedef struct packed {
    logic [ROB_W-1:0] tag;
    logic [XLEN-1:0]  data;
    logic             ld;
    logic             jmp;
    logic [XLEN-1:0]  tgt;
  } bus_t;

  logic             clk = 1'b0;
  logic             rst, ena, in_rollback;
  logic [OP_W-1:0]  in_op;
  logic [XLEN-1:0]  in_Vj, in_Vk, in_imm, in_pc;
  logic [ROB_W-1:0] in_rob_tag;
  logic [ROB_W-1:0] out_cdb_rob_tag;
  logic [XLEN-1:0]  out_cdb_data, out_cdb_target;
  logic             out_cdb_isload, out_cdb_jump;

  int   n_vec = 0;
  int   n_err = 0;
  bus_t exp_q = '0;

  alu_exec_stage #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_rollback(in_rollback),
    .in_op(in_op), .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm),
    .in_pc(in_pc), .in_rob_tag(in_rob_tag),
    .out_cdb_rob_tag(out_cdb_rob_tag), .out_cdb_data(out_cdb_data),
    .out_cdb_isload(out_cdb_isload), .out_cdb_jump(out_cdb_jump),
    .out_cdb_target(out_cdb_target)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: what the bus should show after capturing one operation.
  function automatic bus_t ref_model(input int op, input logic [31:0] vj, input logic [31:0] vk,
                                     input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    bus_t r;
    longint uj, uk, ui, up;
    int sj, sk, si;
    logic signed [31:0] sv;
    r = '0;
    uj = longint'(vj); uk = longint'(vk); ui = longint'(imm); up = longint'(pc);
    sj = int'(vj); sk = int'(vk); si = int'(imm);
    sv = vj;
    if (tag == 0) return '0;
    case (op)
      ADD:   r.data = 32'(uj + uk);
      SUB:   r.data = 32'(uj - uk);
      SLL:   r.data = vj << vk[4:0];
      SLT:   r.data = (sj < sk) ? 1 : 0;
      SLTU:  r.data = (uj < uk) ? 1 : 0;
      XOR:   r.data = vj ^ vk;
      SRL:   r.data = vj >> vk[4:0];
      SRA:   r.data = 32'(sv >>> vk[4:0]);
      OR:    r.data = vj | vk;
      AND:   r.data = vj & vk;
      ADDI:  r.data = 32'(uj + ui);
      SLTI:  r.data = (sj < si) ? 1 : 0;
      SLTIU: r.data = (uj < ui) ? 1 : 0;
      XORI:  r.data = vj ^ imm;
      ORI:   r.data = vj | imm;
      ANDI:  r.data = vj & imm;
      SLLI:  r.data = vj << imm[4:0];
      SRLI:  r.data = vj >> imm[4:0];
      SRAI:  r.data = 32'(sv >>> imm[4:0]);
      LUI:   r.data = imm;
      AUIPC: r.data = 32'(up + ui);
      JAL:   begin r.data = 32'(up + 4); r.tgt = 32'(up + ui); r.jmp = 1; end
      JALR:  begin r.data = 32'(up + 4); r.tgt = 32'(uj + ui) & ~32'd1; r.jmp = 1; end
      BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
        case (op)
          BEQ:     r.jmp = (uj == uk);
          BNE:     r.jmp = (uj != uk);
          BLT:     r.jmp = (sj <  sk);
          BGE:     r.jmp = (sj >= sk);
          BLTU:    r.jmp = (uj <  uk);
          default: r.jmp = (uj >= uk);
        endcase
        r.tgt = r.jmp ? 32'(up + ui) : 32'(up + 4);
      end
      LB, LH, LW, LBU, LHU, SB, SH, SW: begin r.data = 32'(uj + ui); r.ld = 1; end
      default: return '0;
    endcase
    r.tag = tag;
    return r;
  endfunction

  // Drive one cycle, advance the model, then compare every bus field.
  task automatic apply(input bit r, input bit e, input bit rb, input int op,
                       input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [3:0] tag);
    rst = r; ena = e; in_rollback = rb; in_op = OP_W'(op);
    in_Vj = vj; in_Vk = vk; in_imm = imm; in_pc = pc; in_rob_tag = tag;
    @(posedge clk);
    if (r)        exp_q = '0;
    else if (e)   exp_q = rb ? '0 : ref_model(op, vj, vk, imm, pc, tag);
    #1;
    check_eq("tag",    32'(out_cdb_rob_tag), 32'(exp_q.tag));
    check_eq("data",   out_cdb_data,         exp_q.data);
    check_eq("isload", 32'(out_cdb_isload),  32'(exp_q.ld));
    check_eq("jump",   32'(out_cdb_jump),    32'(exp_q.jmp));
    check_eq("target", out_cdb_target,       exp_q.tgt);
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] corners [6];
    corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1F};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    rst = 1'b1; ena = 1'b1; in_rollback = 1'b0; in_op = '0;
    in_Vj = '0; in_Vk = '0; in_imm = '0; in_pc = '0; in_rob_tag = '0;

    // Reset with live ADD inputs
    apply(1, 1, 0, ADD, 5, 7, 0, 0, 3);
    apply(1, 1, 0, ADD, 5, 7, 0, 0, 3);
    check_eq("rst_tag", 32'(out_cdb_rob_tag), 32'd0);
    apply(0, 1, 0, ADD, 5, 7, 0, 0, 3);
    check_eq("add_tag", 32'(out_cdb_rob_tag), 32'd3);
    check_eq("add_data", out_cdb_data, 32'd12);

    // Width and sign cases
    apply(0, 1, 0, SUB, 0, 1, 0, 0, 1);
    check_eq("sub_wrap", out_cdb_data, 32'hFFFFFFFF);
    apply(0, 1, 0, SRA, 32'h80000000, 32'h21, 0, 0, 2);
    check_eq("sra_sh1", out_cdb_data, 32'hC0000000);
    apply(0, 1, 0, SLT, 32'hFFFFFFFF, 1, 0, 0, 3);
    check_eq("slt_neg", out_cdb_data, 32'd1);
    apply(0, 1, 0, SLTU, 32'hFFFFFFFF, 1, 0, 0, 4);
    check_eq("sltu_big", out_cdb_data, 32'd0);
    apply(0, 1, 0, ADD, 32'hFFFFFFFF, 1, 0, 0, 5);
    check_eq("add_wrap", out_cdb_data, 32'd0);

    // Control transfers
    apply(0, 1, 0, BNE, 1, 2, 32'h20, 32'h100, 6);
    check_eq("bne_tgt", out_cdb_target, 32'h120);
    check_eq("bne_jmp", 32'(out_cdb_jump), 32'd1);
    apply(0, 1, 0, BGEU, 1, 32'hFFFFFFFF, 32'h20, 32'h100, 7);
    check_eq("bgeu_tgt", out_cdb_target, 32'h104);
    check_eq("bgeu_jmp", 32'(out_cdb_jump), 32'd0);
    apply(0, 1, 0, JALR, 32'h1001, 0, 2, 32'h200, 8);
    check_eq("jalr_data", out_cdb_data, 32'h204);
    check_eq("jalr_tgt", out_cdb_target, 32'h1002);

    // Memory address generation
    apply(0, 1, 0, LW, 32'h1000, 0, 32'hFFFFFFFC, 0, 5);
    check_eq("lw_addr", out_cdb_data, 32'h0FFC);
    check_eq("lw_ld", 32'(out_cdb_isload), 32'd1);
    apply(0, 1, 0, SW, 32'h2000, 32'h55, 8, 0, 9);
    check_eq("sw_ld", 32'(out_cdb_isload), 32'd1);

    // Stall holds, then idle capture and flush
    apply(0, 1, 0, ADD, 100, 23, 0, 0, 10);
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, SUB, $urandom, $urandom, 0, 0, 11);
      check_eq("stall_data", out_cdb_data, 32'd123);
    end
    apply(0, 1, 0, NOP, 1, 2, 0, 0, 12);
    check_eq("nop_tag", 32'(out_cdb_rob_tag), 32'd0);
    apply(0, 1, 0, ADD, 1, 1, 0, 0, 4);
    apply(0, 1, 1, ADD, 1, 1, 0, 0, 4);
    check_eq("rb_tag", 32'(out_cdb_rob_tag), 32'd0);
    apply(0, 1, 0, 50, 1, 1, 0, 0, 4);
    check_eq("unk_tag", 32'(out_cdb_rob_tag), 32'd0);

    // Back-to-back stream
    for (int i = 1; i <= 4; i++) begin
      apply(0, 1, 0, ADDI, 32'(i * 10), 0, 32'(i), 0, 4'(i));
      check_eq("stream_tag", 32'(out_cdb_rob_tag), 32'(i));
      check_eq("stream_data", out_cdb_data, 32'(i * 11));
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int op;
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(1, 37));
      apply($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
            op, rand_val(), rand_val(), rand_val(), rand_val(), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
